axi2apb_sched: RTL

Sequencing and arbitration controller for the APB side of the AXI-to-APB bridge. Accepts single-beat read and write requests from the AXI read and write channel front-ends and arbitrates between them round-robin. Runs each granted request through the APB SETUP/ACCESS protocol, driving `ctrl_psel`, `ctrl_addr_mux` and the shared `paddr`/`pwrite`/`pwdata`/`penable` into `axi2apb_mux`. Returns read data and error status to the front-ends and bounds hung slaves with an access timeout.

---
 rtl/axi2apb_pkg.sv | 19 +
 rtl/axi2apb_rr_arb.sv | 43 ++++
 rtl/axi2apb_sched.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/axi2apb_pkg.sv
// Shared types and constants for the AXI-to-APB bridge APB-side controller.
package axi2apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   typedef enum logic {
      GNT_WR = 1'b0,
      GNT_RD = 1'b1
   } apb_grant_e;

   localparam int APB_DATA_W = 32;
   localparam int APB_ADDR_W = 32;

endpackage

// File: rtl/axi2apb_rr_arb.sv
// Two-requester round-robin arbiter; grant[0] is the write side, grant[1] the read side.
module axi2apb_rr_arb
   import axi2apb_pkg::*;
(
   input  logic       ACLK,
   input  logic       ARESETn,
   input  logic       wr_valid,
   input  logic       rd_valid,
   input  logic       advance,
   output logic [1:0] grant
);

   apb_grant_e last_grant_r;

   // On a tie the side not granted last wins
   always_comb begin
      grant = 2'b00;
      if (wr_valid && rd_valid) begin
         if (last_grant_r == GNT_WR) begin
            grant = 2'b10;
         end else begin
            grant = 2'b01;
         end
      end else if (wr_valid) begin
         grant = 2'b01;
      end else if (rd_valid) begin
         grant = 2'b10;
      end else begin
         grant = 2'b00;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         last_grant_r <= GNT_WR;
      end else if (advance && (grant != 2'b00)) begin
         last_grant_r <= grant[1] ? GNT_RD : GNT_WR;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

endmodule

// File: rtl/axi2apb_sched.sv
// APB-side sequencer: arbitrates read/write requests, runs APB SETUP/ACCESS,
// returns responses and bounds hung slaves with an access timeout.
module axi2apb_sched
   import axi2apb_pkg::*;
#(
   parameter int ADDR_MUX_LSB   = 12,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic                  wr_req_valid,
   output logic                  wr_req_ready,
   input  logic [APB_ADDR_W-1:0] wr_req_addr,
   input  logic [APB_DATA_W-1:0] wr_req_data,
   input  logic                  rd_req_valid,
   output logic                  rd_req_ready,
   input  logic [APB_ADDR_W-1:0] rd_req_addr,
   output logic                  wr_rsp_valid,
   input  logic                  wr_rsp_ready,
   output logic                  wr_rsp_err,
   output logic                  rd_rsp_valid,
   input  logic                  rd_rsp_ready,
   output logic [APB_DATA_W-1:0] rd_rsp_data,
   output logic                  rd_rsp_err,
   output logic [APB_ADDR_W-1:0] paddr,
   output logic                  pwrite,
   output logic [APB_DATA_W-1:0] pwdata,
   output logic                  penable,
   output logic                  ctrl_psel,
   output logic [3:0]            ctrl_addr_mux,
   input  logic [APB_DATA_W-1:0] ctrl_prdata,
   input  logic                  ctrl_pready,
   input  logic                  ctrl_pslverr
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic             TO_EN    = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;

   apb_state_e            state_r;
   apb_state_e            state_s;
   logic [1:0]            grant_s;
   logic                  accept_s;
   logic                  timeout_s;
   logic                  rsp_ready_s;
   logic [APB_ADDR_W-1:0] paddr_r;
   logic [APB_DATA_W-1:0] pwdata_r;
   logic                  pwrite_r;
   logic [APB_DATA_W-1:0] rdata_r;
   logic                  err_r;
   logic [CNT_W-1:0]      cnt_r;

   axi2apb_rr_arb u_arb (
      .ACLK     (ACLK),
      .ARESETn  (ARESETn),
      .wr_valid (wr_req_valid),
      .rd_valid (rd_req_valid),
      .advance  (accept_s),
      .grant    (grant_s)
   );

   assign rsp_ready_s = pwrite_r ? wr_rsp_ready : rd_rsp_ready;

   // Next-state decode; an in-range pready always beats the timeout
   always_comb begin
      state_s   = state_r;
      accept_s  = 1'b0;
      timeout_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (grant_s != 2'b00) begin
               accept_s = 1'b1;
               state_s  = SETUP;
            end else begin
               state_s  = IDLE;
            end
         end
         SETUP: begin
            state_s = ACCESS;
         end
         ACCESS: begin
            if (ctrl_pready) begin
               state_s = RESP;
            end else if (TO_EN && (cnt_r == CNT_LAST)) begin
               timeout_s = 1'b1;
               state_s   = RESP;
            end else begin
               state_s = ACCESS;
            end
         end
         RESP: begin
            if (rsp_ready_s) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Request capture and response data/status capture
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         paddr_r  <= {APB_ADDR_W{1'b0}};
         pwdata_r <= {APB_DATA_W{1'b0}};
         pwrite_r <= 1'b0;
         rdata_r  <= {APB_DATA_W{1'b0}};
         err_r    <= 1'b0;
      end else begin
         if (accept_s) begin
            paddr_r  <= grant_s[1] ? rd_req_addr : wr_req_addr;
            pwrite_r <= grant_s[0];
            if (grant_s[0]) begin
               pwdata_r <= wr_req_data;
            end
         end
         if (state_r == ACCESS) begin
            if (ctrl_pready) begin
               err_r <= ctrl_pslverr;
               if (!pwrite_r) begin
                  rdata_r <= ctrl_prdata;
               end
            end else if (timeout_s) begin
               err_r   <= 1'b1;
               rdata_r <= {APB_DATA_W{1'b0}};
            end
         end
      end
   end

   // Saturating ACCESS wait counter, cleared while in SETUP
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == SETUP) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ACCESS) && !ctrl_pready && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // ARESETn gating keeps ready low for the whole reset, not only after the first edge
   assign wr_req_ready  = ARESETn & (state_r == IDLE) & grant_s[0];
   assign rd_req_ready  = ARESETn & (state_r == IDLE) & grant_s[1];
   assign ctrl_psel     = (state_r == SETUP) || (state_r == ACCESS);
   assign penable       = (state_r == ACCESS);
   assign wr_rsp_valid  = (state_r == RESP) & pwrite_r;
   assign rd_rsp_valid  = (state_r == RESP) & ~pwrite_r;
   assign wr_rsp_err    = err_r & pwrite_r;
   assign rd_rsp_err    = err_r & ~pwrite_r;
   assign rd_rsp_data   = rdata_r;
   assign paddr         = paddr_r;
   assign pwrite        = pwrite_r;
   assign pwdata        = pwdata_r;
   assign ctrl_addr_mux = paddr_r[ADDR_MUX_LSB +: 4];

endmodule
